// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and
// elaboration-time sizing helpers.
package reset_seq_pkg;

  localparam logic [1:0] ST_HOLD     = 2'd0;
  localparam logic [1:0] ST_WAIT_ACK = 2'd1;
  localparam logic [1:0] ST_GAP      = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  // Number of bits needed to index 'value' distinct items (value >= 2).
  function automatic int clog2_int(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/reset_seq.sv
// Power-on reset sequencer: holds every downstream domain in reset, then
// releases them one at a time, waiting for each ack (or a timeout) in between.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int NR_STAGES   = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sw_rst_req,
  input  logic [NR_STAGES-1:0] stage_ack,
  output logic [NR_STAGES-1:0] stage_rst,
  output logic                 all_ready,
  output logic                 timeout_err,
  output logic [3:0]           cur_stage
);

  localparam int CW = clog2_int(max3(HOLD_CYCLES, STAGE_GAP, ACK_TIMEOUT) + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(ACK_TIMEOUT - 1);
  localparam logic [3:0]    LAST_STG  = 4'(NR_STAGES - 1);

  logic [1:0]    state;
  logic [CW-1:0] counter;
  logic          ack_sel;

  // Handshake: once stage_rst[i] falls, the stage raises stage_ack[i] when it
  // is ready; the ack is sampled only while that stage is the one awaited.
  always_comb begin
    ack_sel = 1'b0;
    for (int i = 0; i < NR_STAGES; i++) begin
      if (cur_stage == 4'(i)) ack_sel = stage_ack[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_HOLD;
      counter     <= '0;
      stage_rst   <= '1;
      all_ready   <= 1'b0;
      timeout_err <= 1'b0;
      cur_stage   <= 4'd0;
    end else if (sw_rst_req) begin
      // Restart is a reset that keeps the sticky timeout record.
      state     <= ST_HOLD;
      counter   <= '0;
      stage_rst <= '1;
      all_ready <= 1'b0;
      cur_stage <= 4'd0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (counter == HOLD_LAST) begin
            stage_rst <= stage_rst << 1;
            cur_stage <= 4'd0;
            counter   <= '0;
            state     <= ST_WAIT_ACK;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          if (ack_sel || (counter == TO_LAST)) begin
            // An ack on the terminal edge wins over the timeout.
            if (!ack_sel) timeout_err <= 1'b1;
            if (cur_stage == LAST_STG) begin
              all_ready <= 1'b1;
              state     <= ST_DONE;
            end else begin
              counter <= '0;
              state   <= ST_GAP;
            end
          end else begin
            counter <= counter + 1'b1;
          end
        end
        ST_GAP: begin
          if (counter == GAP_LAST) begin
            // Stages release strictly in order, so a left shift frees the next one.
            stage_rst <= stage_rst << 1;
            cur_stage <= cur_stage + 4'd1;
            counter   <= '0;
            state     <= ST_WAIT_ACK;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        ST_DONE: begin
          all_ready <= 1'b1;
          stage_rst <= '0;
        end
        default: begin
          state   <= ST_HOLD;
          counter <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_seq.sv
// Self-checking bench for reset_seq: directed timeline scenarios plus random
// acks/restarts/resets compared against a timestamp-based reference model.
module tb_reset_seq;

  localparam int N = 3;
  localparam int H = 4;
  localparam int G = 2;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sw_rst_req = 1'b0;
  logic [N-1:0] stage_ack = '0;
  logic [N-1:0] stage_rst;
  logic         all_ready;
  logic         timeout_err;
  logic [3:0]   cur_stage;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  int base     = 0;

  // Reference model: number of released stages plus absolute edge timestamps.
  int m_released;
  int m_release_at;
  int m_wait_since;
  bit m_ready;
  bit m_tout;

  always #5 clk = ~clk;

  reset_seq #(
    .NR_STAGES  (N),
    .HOLD_CYCLES(H),
    .STAGE_GAP  (G),
    .ACK_TIMEOUT(T)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_rst_req (sw_rst_req),
    .stage_ack  (stage_ack),
    .stage_rst  (stage_rst),
    .all_ready  (all_ready),
    .timeout_err(timeout_err),
    .cur_stage  (cur_stage)
  );

  wire [N+5:0] obs = {stage_rst, all_ready, timeout_err, cur_stage};

  function automatic void model_edge(input bit r, input bit sw, input logic [N-1:0] ack,
                                     input int n);
    bit a;
    if (r || sw) begin
      m_released   = 0;
      m_ready      = 1'b0;
      m_wait_since = -1;
      m_release_at = n + H;
      if (r) m_tout = 1'b0;
    end else if (m_ready) begin
      m_ready = 1'b1;
    end else if (m_wait_since >= 0) begin
      a = ((ack >> (m_released - 1)) & 1) != 0;
      if (a || (n - m_wait_since) == T) begin
        if (!a) m_tout = 1'b1;
        if (m_released == N) m_ready = 1'b1;
        else m_release_at = n + G;
        m_wait_since = -1;
      end
    end else if (n == m_release_at) begin
      m_released++;
      m_wait_since = n;
    end
  endfunction

  function automatic logic [N+5:0] model_out();
    logic [N-1:0] m;
    int cs;
    m  = '1;
    m  = m << m_released;
    cs = (m_released == 0) ? 0 : m_released - 1;
    return {m, m_ready, m_tout, 4'(cs)};
  endfunction

  task automatic tick();
    @(posedge clk);
    edge_n++;
    model_edge(reset, sw_rst_req, stage_ack, edge_n);
    #1;
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    sw_rst_req = 1'b0;
    tick();
    reset = 1'b0;
    base  = edge_n;
  endtask

  task automatic test_reset();
    stage_ack = '0;
    apply_reset();
    n_checks++;
    if (obs !== 9'b111_0_0_0000) begin
      n_fail++;
      $display("FAIL reset_values: got %b want %b", obs, 9'b111_0_0_0000);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++;
      if (obs !== model_out() || stage_rst !== 3'b111) begin
        n_fail++;
        $display("FAIL reset_hold edge %0d: got %b want %b", k, obs, model_out());
      end
    end
  endtask

  task automatic test_nominal();
    stage_ack = '1;
    apply_reset();
    for (int k = 1; k <= 14; k++) begin
      if (k == 13) stage_ack = '0;
      tick();
      n_checks++;
      if (obs !== model_out()) begin
        n_fail++;
        $display("FAIL nominal_model edge %0d: got %b want %b", k, obs, model_out());
      end
      if ((k == 3 && stage_rst !== 3'b111) || (k == 4 && stage_rst !== 3'b110) ||
          (k == 6 && stage_rst !== 3'b110) || (k == 7 && stage_rst !== 3'b100) ||
          (k == 10 && (stage_rst !== 3'b000 || all_ready !== 1'b0)) ||
          (k == 11 && all_ready !== 1'b1) ||
          (k == 14 && (stage_rst !== 3'b000 || all_ready !== 1'b1 || timeout_err !== 1'b0))) begin
        n_fail++;
        $display("FAIL nominal_timeline edge %0d: got rst=%b rdy=%b to=%b", k, stage_rst,
                 all_ready, timeout_err);
      end
      if (k inside {3, 4, 6, 7, 10, 11, 14}) n_checks++;
    end
  endtask

  task automatic test_stage1_timeout();
    stage_ack = 3'b101;
    apply_reset();
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_checks++;
      if (obs !== model_out()) begin
        n_fail++;
        $display("FAIL stage1_model edge %0d: got %b want %b", k, obs, model_out());
      end
      if ((k == 7 && stage_rst !== 3'b100) || (k == 14 && timeout_err !== 1'b0) ||
          (k == 15 && timeout_err !== 1'b1) || (k == 16 && stage_rst !== 3'b100) ||
          (k == 17 && (stage_rst !== 3'b000 || all_ready !== 1'b0)) ||
          (k == 18 && all_ready !== 1'b1)) begin
        n_fail++;
        $display("FAIL stage1_timeline edge %0d: got rst=%b rdy=%b to=%b", k, stage_rst,
                 all_ready, timeout_err);
      end
      if (k inside {7, 14, 15, 16, 17, 18}) n_checks++;
    end
  endtask

  task automatic test_ack_timeout_same_edge();
    stage_ack = '0;
    apply_reset();
    for (int k = 1; k <= 16; k++) begin
      if (k == 12) stage_ack = 3'b001;
      tick();
      n_checks++;
      if (obs !== model_out()) begin
        n_fail++;
        $display("FAIL same_edge_model edge %0d: got %b want %b", k, obs, model_out());
      end
      if ((k == 12 && (timeout_err !== 1'b0 || stage_rst !== 3'b110)) ||
          (k == 14 && (stage_rst !== 3'b100 || cur_stage !== 4'd1)) ||
          (k == 16 && timeout_err !== 1'b0)) begin
        n_fail++;
        $display("FAIL same_edge_timeline edge %0d: got rst=%b cur=%0d to=%b", k, stage_rst,
                 cur_stage, timeout_err);
      end
      if (k inside {12, 14, 16}) n_checks++;
    end
  endtask

  task automatic test_sw_pulse();
    stage_ack = '1;
    apply_reset();
    for (int k = 1; k <= 14; k++) begin
      sw_rst_req = (k == 6);
      tick();
      n_checks++;
      if (obs !== model_out()) begin
        n_fail++;
        $display("FAIL sw_pulse_model edge %0d: got %b want %b", k, obs, model_out());
      end
      if ((k == 5 && stage_rst !== 3'b110) ||
          (k == 6 && (stage_rst !== 3'b111 || cur_stage !== 4'd0 || all_ready !== 1'b0)) ||
          (k == 9 && stage_rst !== 3'b111) || (k == 10 && stage_rst !== 3'b110)) begin
        n_fail++;
        $display("FAIL sw_pulse_timeline edge %0d: got rst=%b cur=%0d", k, stage_rst, cur_stage);
      end
      if (k inside {5, 6, 9, 10}) n_checks++;
    end
    sw_rst_req = 1'b0;
  endtask

  task automatic test_sw_held();
    stage_ack = '1;
    apply_reset();
    for (int k = 1; k <= 16; k++) begin
      sw_rst_req = (k >= 6 && k <= 10);
      tick();
      n_checks++;
      if (obs !== model_out()) begin
        n_fail++;
        $display("FAIL sw_held_model edge %0d: got %b want %b", k, obs, model_out());
      end
      if ((k >= 6 && k <= 13 && stage_rst !== 3'b111) || (k == 14 && stage_rst !== 3'b110)) begin
        n_fail++;
        $display("FAIL sw_held_timeline edge %0d: got rst=%b", k, stage_rst);
      end
      if (k >= 6 && k <= 14) n_checks++;
    end
    sw_rst_req = 1'b0;
  endtask

  task automatic test_timeout_restart();
    stage_ack = '0;
    apply_reset();
    for (int k = 1; k <= 16; k++) begin
      sw_rst_req = (k == 14);
      tick();
      n_checks++;
      if (obs !== model_out()) begin
        n_fail++;
        $display("FAIL restart_model edge %0d: got %b want %b", k, obs, model_out());
      end
      if ((k == 11 && timeout_err !== 1'b0) || (k == 12 && timeout_err !== 1'b1) ||
          (k == 14 && (timeout_err !== 1'b1 || stage_rst !== 3'b111))) begin
        n_fail++;
        $display("FAIL restart_timeline edge %0d: got rst=%b to=%b", k, stage_rst, timeout_err);
      end
      if (k inside {11, 12, 14}) n_checks++;
    end
    sw_rst_req = 1'b0;
    apply_reset();
    n_checks++;
    if (obs !== 9'b111_0_0_0000) begin
      n_fail++;
      $display("FAIL restart_reset_clear: got %b want %b", obs, 9'b111_0_0_0000);
    end
  endtask

  task automatic test_random();
    int fast;
    stage_ack = '0;
    apply_reset();
    fast = 0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 199) == 0) fast = $urandom_range(0, 1);
      for (int i = 0; i < N; i++)
        stage_ack[i] = (fast != 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 5) == 0);
      sw_rst_req = ($urandom_range(0, 119) == 0);
      reset      = ($urandom_range(0, 399) == 0);
      tick();
      n_checks++;
      if (obs !== model_out()) begin
        n_fail++;
        $display("FAIL random_model cycle %0d: got %b want %b", k, obs, model_out());
      end
    end
    reset      = 1'b0;
    sw_rst_req = 1'b0;
  endtask

  initial begin
    m_released   = 0;
    m_release_at = 0;
    m_wait_since = -1;
    m_ready      = 1'b0;
    m_tout       = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_nominal();
    test_stage1_timeout();
    test_ack_timeout_same_edge();
    test_sw_pulse();
    test_sw_held();
    test_timeout_restart();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
